// File: rtl/decimal_entry_to_binary_pkg.sv
// Shared types and constants for the decimal digit entry block.
package decimal_entry_pkg;
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } dec_state_e;

    localparam int         DEC_BASE      = 10;
    localparam logic [3:0] MAX_DEC_DIGIT = 4'd9;
endpackage

// File: rtl/decimal_entry_to_binary_if.sv
// Digit entry bus: keypad-side controls in, committed value and status out.
// Handshake: a digit or enter is taken on a rising edge only while digit_ready is high; clear is always taken.
interface decimal_entry_to_binary_if #(
    parameter int OUT_W = 9,
    parameter int CNT_W = 2
);
    logic             digit_valid;
    logic [3:0]       digit;
    logic             enter;
    logic             clear;
    logic             digit_ready;
    logic [OUT_W-1:0] value_out;
    logic             value_valid;
    logic [CNT_W-1:0] digit_count;
    logic             err_invalid;
    logic             err_ovf;
    logic [0:0]       dbg_state;

    modport master (
        output digit_valid, digit, enter, clear,
        input  digit_ready, value_out, value_valid, digit_count, err_invalid, err_ovf, dbg_state
    );

    modport slave (
        input  digit_valid, digit, enter, clear,
        output digit_ready, value_out, value_valid, digit_count, err_invalid, err_ovf, dbg_state
    );
endinterface

// File: rtl/decimal_entry_to_binary_times_ten_add.sv
// Combinational acc*10 + digit using shifts and adds, widened so overflow is visible.
module times_ten_add #(
    parameter int OUT_W = 9
) (
    input  logic [OUT_W-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [OUT_W+3:0] sum_o
);
    logic [OUT_W+3:0] acc_w;

    assign acc_w = {4'b0000, acc_i};
    assign sum_o = (acc_w << 3) + (acc_w << 1) + {{OUT_W{1'b0}}, digit_i};
endmodule

// File: rtl/decimal_entry_to_binary.sv
// Accumulates decimal digits MSD-first into a binary value committed on enter.
// DEC_ENTRY_TIMEOUT_EN adds an idle auto-commit after TIMEOUT_CYC cycles.
module decimal_entry_to_binary
    import decimal_entry_pkg::*;
#(
    parameter int OUT_W       = 9,
    parameter int MAX_DIGITS  = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input logic clk,
    input logic reset,
    decimal_entry_to_binary_if.slave bus
);
    localparam int         CNT_W  = $clog2(MAX_DIGITS + 1);
    localparam logic [0:0] S_IDLE = ST_IDLE;
    localparam logic [0:0] S_MUL  = ST_MUL;

    logic [0:0]       state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dig_q, dig_d;
    logic [OUT_W-1:0] val_q, val_d;
    logic             vv_q, vv_d;
    logic             einv_q, einv_d;
    logic             eovf_q, eovf_d;
    logic [OUT_W+3:0] sum;
    logic             timeout_hit;

    times_ten_add #(.OUT_W(OUT_W)) u_mul (
        .acc_i   (acc_q),
        .digit_i (dig_q),
        .sum_o   (sum)
    );

`ifdef DEC_ENTRY_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_q, idle_d;
    logic            idle_cnt_en;

    // Counting only happens while a partial entry sits untouched in IDLE.
    assign idle_cnt_en = (state_q == S_IDLE) && (cnt_q != '0) && !bus.clear
                         && !bus.enter && !bus.digit_valid;
    assign timeout_hit = idle_cnt_en && (idle_q == TO_W'(TIMEOUT_CYC - 1));
    assign idle_d      = (idle_cnt_en && !timeout_hit) ? idle_q + 1'b1 : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) idle_q <= '0;
        else       idle_q <= idle_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        val_d   = val_q;
        vv_d    = 1'b0;
        einv_d  = einv_q;
        eovf_d  = eovf_q;
        if (bus.clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            einv_d  = 1'b0;
            eovf_d  = 1'b0;
        end else if (state_q == S_MUL) begin
            state_d = S_IDLE;
            if (|sum[OUT_W+3:OUT_W]) begin
                eovf_d = 1'b1;
            end else begin
                acc_d = sum[OUT_W-1:0];
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.enter || timeout_hit) begin
            val_d = acc_q;
            vv_d  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
        end else if (bus.digit_valid) begin
            if (bus.digit > MAX_DEC_DIGIT) begin
                einv_d = 1'b1;
            end else if (cnt_q == CNT_W'(MAX_DIGITS)) begin
                eovf_d = 1'b1;
            end else begin
                dig_d   = bus.digit;
                state_d = S_MUL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            val_q   <= '0;
            vv_q    <= 1'b0;
            einv_q  <= 1'b0;
            eovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            val_q   <= val_d;
            vv_q    <= vv_d;
            einv_q  <= einv_d;
            eovf_q  <= eovf_d;
        end
    end

    assign bus.digit_ready = (state_q == S_IDLE);
    assign bus.value_out   = val_q;
    assign bus.value_valid = vv_q;
    assign bus.digit_count = cnt_q;
    assign bus.err_invalid = einv_q;
    assign bus.err_ovf     = eovf_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_decimal_entry_to_binary.sv
// Directed bench for decimal_entry_to_binary: vector table plus corner sequences.
module tb_decimal_entry_to_binary;
    localparam int OUT_W = 9;
    localparam int CNT_W = 2;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [OUT_W-1:0] exp_q[$];

    decimal_entry_to_binary_if #(.OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

    decimal_entry_to_binary #(
        .OUT_W(OUT_W), .MAX_DIGITS(3), .TIMEOUT_CYC(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      digits;
        int               n;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_ovf;
        logic [OUT_W-1:0] exp_val;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        tick();
        bus.digit_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    // Enter, then verify the one-cycle commit pulse against the scoreboard.
    task automatic do_enter(input logic [OUT_W-1:0] expv, input string name);
        logic [OUT_W-1:0] e;
        exp_q.push_back(expv);
        bus.enter = 1'b1;
        tick();
        bus.enter = 1'b0;
        check({name, " valid"}, int'(bus.value_valid), 1);
        e = exp_q.pop_front();
        check({name, " value"}, int'(bus.value_out), int'(e));
        check({name, " count0"}, int'(bus.digit_count), 0);
        tick();
        check({name, " pulse1"}, int'(bus.value_valid), 0);
    endtask

    initial begin
        logic [OUT_W-1:0] held;
        total = 0;
        bad   = 0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.enter       = 1'b0;
        bus.clear       = 1'b0;

        vecs[0] = '{digits: 16'h3100, n: 2, exp_cnt: 2'd2, exp_ovf: 1'b0, exp_val: 9'd31};
        vecs[1] = '{digits: 16'h5110, n: 3, exp_cnt: 2'd3, exp_ovf: 1'b0, exp_val: 9'd511};
        vecs[2] = '{digits: 16'h5120, n: 3, exp_cnt: 2'd2, exp_ovf: 1'b1, exp_val: 9'd51};
        vecs[3] = '{digits: 16'h1234, n: 4, exp_cnt: 2'd3, exp_ovf: 1'b1, exp_val: 9'd123};
        vecs[4] = '{digits: 16'h0000, n: 1, exp_cnt: 2'd1, exp_ovf: 1'b0, exp_val: 9'd0};
        vecs[5] = '{digits: 16'h0000, n: 0, exp_cnt: 2'd0, exp_ovf: 1'b0, exp_val: 9'd0};
        vecs[6] = '{digits: 16'h9900, n: 2, exp_cnt: 2'd2, exp_ovf: 1'b0, exp_val: 9'd99};
        vecs[7] = '{digits: 16'h6000, n: 3, exp_cnt: 2'd2, exp_ovf: 1'b1, exp_val: 9'd60};
        vecs[8] = '{digits: 16'h2550, n: 3, exp_cnt: 2'd3, exp_ovf: 1'b0, exp_val: 9'd255};

        reset = 1'b1;
        #12;
        check("rst ready", int'(bus.digit_ready), 1);
        check("rst value", int'(bus.value_out), 0);
        check("rst valid", int'(bus.value_valid), 0);
        check("rst count", int'(bus.digit_count), 0);
        check("rst errinv", int'(bus.err_invalid), 0);
        check("rst errovf", int'(bus.err_ovf), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            pulse_clear();
            for (int i = 0; i < vecs[v].n; i++)
                send_digit(vecs[v].digits[15 - 4*i -: 4]);
            check($sformatf("vec%0d count", v), int'(bus.digit_count), int'(vecs[v].exp_cnt));
            check($sformatf("vec%0d ovf", v), int'(bus.err_ovf), int'(vecs[v].exp_ovf));
            check($sformatf("vec%0d inv", v), int'(bus.err_invalid), 0);
            do_enter(vecs[v].exp_val, $sformatf("vec%0d", v));
            check($sformatf("vec%0d ovf kept", v), int'(bus.err_ovf), int'(vecs[v].exp_ovf));
        end

        // Busy cycle: ready drops for exactly the multiply cycle.
        pulse_clear();
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd4;
        tick();
        bus.digit_valid = 1'b0;
        check("mul ready", int'(bus.digit_ready), 0);
        tick();
        check("idle ready", int'(bus.digit_ready), 1);
        check("mul count", int'(bus.digit_count), 1);
        do_enter(9'd4, "thru");

        // Invalid digit keeps acc; clear wipes errors but not value_out.
        pulse_clear();
        send_digit(4'd7);
        send_digit(4'hA);
        check("inv flag", int'(bus.err_invalid), 1);
        check("inv count", int'(bus.digit_count), 1);
        check("inv ovf", int'(bus.err_ovf), 0);
        held = bus.value_out;
        pulse_clear();
        check("clr inv", int'(bus.err_invalid), 0);
        check("clr count", int'(bus.digit_count), 0);
        check("clr value", int'(bus.value_out), int'(held));
        check("clr novalid", int'(bus.value_valid), 0);
        send_digit(4'd7);
        send_digit(4'hF);
        do_enter(9'd7, "inv acc");
        check("inv sticky", int'(bus.err_invalid), 1);

        // Enter beats a same-cycle digit, without raising an error.
        pulse_clear();
        send_digit(4'd2);
        bus.enter       = 1'b1;
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd7;
        exp_q.push_back(9'd2);
        tick();
        bus.enter       = 1'b0;
        bus.digit_valid = 1'b0;
        check("ed valid", int'(bus.value_valid), 1);
        check("ed value", int'(bus.value_out), int'(exp_q.pop_front()));
        check("ed ready", int'(bus.digit_ready), 1);
        check("ed count", int'(bus.digit_count), 0);
        check("ed errs", int'({bus.err_invalid, bus.err_ovf}), 0);

        // Clear during the multiply cycle discards the pending digit.
        send_digit(4'd5);
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd9;
        tick();
        bus.digit_valid = 1'b0;
        bus.clear       = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("mulclr count", int'(bus.digit_count), 0);
        check("mulclr ready", int'(bus.digit_ready), 1);
        tick();
        check("mulclr count2", int'(bus.digit_count), 0);
        do_enter(9'd0, "mulclr");

        // Enter during MUL is ignored because ready is low.
        send_digit(4'd3);
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd8;
        tick();
        bus.digit_valid = 1'b0;
        bus.enter       = 1'b1;
        tick();
        bus.enter = 1'b0;
        check("mulent novalid", int'(bus.value_valid), 0);
        check("mulent count", int'(bus.digit_count), 2);
        do_enter(9'd38, "mulent");

`ifdef DEC_ENTRY_TIMEOUT_EN
        begin
            int waited;
            bit seen;
            pulse_clear();
            send_digit(4'd4);
            waited = 0;
            seen   = 1'b0;
            while (!seen && waited < 40) begin
                if (bus.value_valid) seen = 1'b1;
                else begin
                    tick();
                    waited++;
                end
            end
            check("to seen", int'(seen), 1);
            check("to value", int'(bus.value_out), 4);
            check("to count", int'(bus.digit_count), 0);
            check("to wait", waited, 8);
        end
`endif

        // Asynchronous reset in the middle of an entry.
        pulse_clear();
        send_digit(4'd6);
        do_enter(9'd6, "pre rst");
        send_digit(4'd1);
        bus.digit_valid = 1'b1;
        bus.digit       = 4'd2;
        tick();
        bus.digit_valid = 1'b0;
        check("pre rst state", int'(bus.dbg_state), 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst ready", int'(bus.digit_ready), 1);
        check("arst value", int'(bus.value_out), 0);
        check("arst count", int'(bus.digit_count), 0);
        check("arst errs", int'({bus.err_invalid, bus.err_ovf, bus.value_valid}), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        do_enter(9'd0, "post rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
